// File: rtl/ber_readout_seq_pkg.sv
// Shared constants, state encoding and command-word builder for the BER readout sequencer.
package ber_readout_seq_pkg;

    localparam int unsigned CMD_W = 32;

    localparam logic [7:0] OP_LOG   = 8'h05;
    localparam logic [7:0] OP_RDSEL = 8'h06;

    localparam int unsigned STROBE_BIT = 23;
    localparam int unsigned RDEN_BIT   = 16;

    typedef enum logic [3:0] {
        StIdle,
        StArm,
        StLatch,
        StDisarm,
        StSel,
        StSettle,
        StPush,
        StRelease,
        StDone
    } state_e;

    function automatic logic [CMD_W-1:0] make_cmd(input logic [7:0]  opcode,
                                                  input logic [23:0] payload);
        return {opcode, payload};
    endfunction

endpackage

// File: rtl/ber_readout_seq_if.sv
// Command-bus arbitration and readback-stream signals of the BER readout sequencer.
interface ber_readout_seq_if #(
    parameter int unsigned NBT_GPIOS = 32
);
    logic                 i_start;
    logic [NBT_GPIOS-1:0] i_gpio_from_micro;
    logic [NBT_GPIOS-1:0] o_gpio_to_regf;
    logic [NBT_GPIOS-1:0] i_regf_to_gpio;
    logic [NBT_GPIOS-1:0] o_data;
    logic                 o_valid;
    logic                 i_ready;
    logic                 o_busy;
    logic                 o_done;
    logic                 o_cmd_dropped;

    modport slave (
        input  i_start, i_gpio_from_micro, i_regf_to_gpio, i_ready,
        output o_gpio_to_regf, o_data, o_valid, o_busy, o_done, o_cmd_dropped
    );

    modport master (
        output i_start, i_gpio_from_micro, i_regf_to_gpio, i_ready,
        input  o_gpio_to_regf, o_data, o_valid, o_busy, o_done, o_cmd_dropped
    );

endinterface

// File: rtl/ber_readout_seq.sv
// Latches the BER accumulators, walks the readback mux and streams the words out,
// passing micro commands through to the register file while idle.
module ber_readout_seq
    import ber_readout_seq_pkg::*;
#(
    parameter int unsigned NBT_GPIOS = 32,
    parameter int unsigned N_WORDS   = 8
) (
    input logic              clk,
    input logic              i_reset,
    ber_readout_seq_if.slave bus
);

    localparam int unsigned   KW     = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_WORDS - 1);

    localparam logic [23:0] PL_STROBE = 24'h1 << STROBE_BIT;
    localparam logic [23:0] PL_RDEN   = 24'h1 << RDEN_BIT;

    localparam logic [NBT_GPIOS-1:0] W_LOG_ON  = NBT_GPIOS'(make_cmd(OP_LOG, PL_STROBE | 24'h1));
    localparam logic [NBT_GPIOS-1:0] W_LOG_OFF = NBT_GPIOS'(make_cmd(OP_LOG, PL_STROBE));
    localparam logic [NBT_GPIOS-1:0] W_RD_OFF  = NBT_GPIOS'(make_cmd(OP_RDSEL, PL_STROBE));

    function automatic logic [NBT_GPIOS-1:0] sel_word(input logic [KW-1:0] idx);
        return NBT_GPIOS'(make_cmd(OP_RDSEL, PL_STROBE | PL_RDEN | 24'(idx)));
    endfunction

    state_e               state_q;
    logic [KW-1:0]        k_q;
    logic                 start_pend_q;
    logic [NBT_GPIOS-1:0] gpio_q;
    logic [NBT_GPIOS-1:0] data_q;
    logic                 valid_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 dropped_q;
    logic                 micro_strobe;

    assign micro_strobe = bus.i_gpio_from_micro[STROBE_BIT];

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= StIdle;
            k_q          <= '0;
            start_pend_q <= 1'b0;
            gpio_q       <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            dropped_q    <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            // The deferred-start cycle also discards the micro word.
            dropped_q <= micro_strobe && ((state_q != StIdle) || start_pend_q);
            unique case (state_q)
                StIdle: begin
                    if (start_pend_q) begin
                        start_pend_q <= 1'b0;
                        gpio_q       <= W_LOG_ON;
                        busy_q       <= 1'b1;
                        state_q      <= StArm;
                    end else if (bus.i_start && micro_strobe) begin
                        // Forward the colliding micro command first; arm one cycle later.
                        start_pend_q <= 1'b1;
                        gpio_q       <= bus.i_gpio_from_micro;
                    end else if (bus.i_start) begin
                        gpio_q  <= W_LOG_ON;
                        busy_q  <= 1'b1;
                        state_q <= StArm;
                    end else begin
                        gpio_q <= bus.i_gpio_from_micro;
                    end
                end
                StArm: begin
                    gpio_q  <= W_LOG_ON;
                    state_q <= StLatch;
                end
                StLatch: begin
                    gpio_q  <= W_LOG_OFF;
                    state_q <= StDisarm;
                end
                StDisarm: begin
                    gpio_q  <= sel_word(k_q);
                    state_q <= StSel;
                end
                StSel: begin
                    gpio_q  <= '0;
                    state_q <= StSettle;
                end
                StSettle: begin
                    data_q  <= bus.i_regf_to_gpio;
                    valid_q <= 1'b1;
                    state_q <= StPush;
                end
                StPush: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        if (k_q == K_LAST) begin
                            k_q     <= '0;
                            gpio_q  <= W_RD_OFF;
                            state_q <= StRelease;
                        end else begin
                            k_q     <= k_q + 1'b1;
                            gpio_q  <= sel_word(k_q + 1'b1);
                            state_q <= StSel;
                        end
                    end
                end
                StRelease: begin
                    gpio_q  <= '0;
                    done_q  <= 1'b1;
                    state_q <= StDone;
                end
                StDone: begin
                    gpio_q  <= '0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    gpio_q  <= '0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    k_q     <= '0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.o_gpio_to_regf = gpio_q;
    assign bus.o_data         = data_q;
    assign bus.o_valid        = valid_q;
    assign bus.o_busy         = busy_q;
    assign bus.o_done         = done_q;
    assign bus.o_cmd_dropped  = dropped_q;

endmodule

// File: tb/tb_ber_readout_seq.sv
// Directed bench for ber_readout_seq: register-file model, stream scoreboard, arbitration checks.
module tb_ber_readout_seq;

    localparam logic [63:0] ERR_I = 64'h0000_0001_0000_0002;
    localparam logic [63:0] BIT_I = 64'h0000_00AB_1234_5678;
    localparam logic [63:0] ERR_Q = 64'h0000_0003_0000_0004;
    localparam logic [63:0] BIT_Q = 64'h0000_00CD_9ABC_DEF0;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ber_readout_seq_if #(.NBT_GPIOS(32)) bus ();

    ber_readout_seq #(
        .NBT_GPIOS(32),
        .N_WORDS  (8)
    ) dut (
        .clk    (clk),
        .i_reset(rst),
        .bus    (bus)
    );

    logic [31:0] stream_ref [8];
    logic [2:0]  regf_sel;
    logic [31:0] sb [$];

    int n_assert = 0;
    int n_fail   = 0;
    int hs_count = 0;
    int done_count = 0;
    int drop_count = 0;
    int leak_count = 0;
    logic        hold_valid = 1'b0;
    logic [31:0] hold_data;

    initial begin
        stream_ref[0] = ERR_I[31:0];
        stream_ref[1] = ERR_I[63:32];
        stream_ref[2] = BIT_I[31:0];
        stream_ref[3] = BIT_I[63:32];
        stream_ref[4] = ERR_Q[31:0];
        stream_ref[5] = ERR_Q[63:32];
        stream_ref[6] = BIT_Q[31:0];
        stream_ref[7] = BIT_Q[63:32];
    end

    // Register-file readback mux: select captured on a strobed read-enable command.
    always @(posedge clk) begin
        if (bus.o_gpio_to_regf[31:24] == 8'h06 && bus.o_gpio_to_regf[23] && bus.o_gpio_to_regf[16])
            regf_sel <= bus.o_gpio_to_regf[2:0];
    end
    assign bus.i_regf_to_gpio = stream_ref[regf_sel];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_bus(input int i);
        int j;
        if (i < 2) return 32'h0580_0001;
        if (i == 2) return 32'h0580_0000;
        if (i == 27) return 32'h0680_0000;
        if (i >= 28) return 32'h0;
        j = i - 3;
        if (j % 3 == 0) return 32'h0681_0000 | 32'(j / 3);
        return 32'h0;
    endfunction

    task automatic push_dump();
        for (int w = 0; w < 8; w++) sb.push_back(stream_ref[w]);
    endtask

    task automatic wait_done(input int max_cycles);
        logic got;
        got = 1'b0;
        for (int t = 0; t < max_cycles && !got; t++) begin
            @(posedge clk);
            #1;
            got = bus.o_done;
        end
        check("done_seen", 32'(got), 32'd1);
    endtask

    // Stream monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst) begin
            hold_valid = 1'b0;
        end else begin
            if (bus.o_done) done_count++;
            if (bus.o_cmd_dropped) drop_count++;
            if (bus.o_gpio_to_regf == 32'h0180_0000) leak_count++;
            if (hold_valid && bus.o_valid) check("data_hold", bus.o_data, hold_data);
            if (bus.o_valid && bus.i_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("stream_word", bus.o_data, sb.pop_front());
                hs_count++;
                hold_valid = 1'b0;
            end else if (bus.o_valid) begin
                hold_valid = 1'b1;
                hold_data  = bus.o_data;
            end else begin
                hold_valid = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base_hs, base_done, base_drop, t;

        rst = 1'b1;
        bus.i_start = 1'b0;
        bus.i_gpio_from_micro = '0;
        bus.i_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_gpio", bus.o_gpio_to_regf, 32'h0);
        check("rst_data", bus.o_data, 32'h0);
        check("rst_valid", 32'(bus.o_valid), 32'h0);
        check("rst_busy", 32'(bus.o_busy), 32'h0);
        check("rst_done", 32'(bus.o_done), 32'h0);
        check("rst_drop", 32'(bus.o_cmd_dropped), 32'h0);
        rst = 1'b0;

        // Micro passthrough with one cycle of latency.
        bus.i_gpio_from_micro = 32'h0280_0001;
        @(posedge clk);
        #1;
        check("pass_word", bus.o_gpio_to_regf, 32'h0280_0001);
        check("pass_busy", 32'(bus.o_busy), 32'h0);
        bus.i_gpio_from_micro = '0;
        @(posedge clk);
        #1;
        check("pass_clear", bus.o_gpio_to_regf, 32'h0);
        bus.i_ready = 1'b1;

        // Full dump, ready tied high: exact bus word sequence ARM..DONE.
        base_hs = hs_count;
        base_done = done_count;
        push_dump();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int i = 0; i < 29; i++) begin
            check($sformatf("bus_word_%0d", i), bus.o_gpio_to_regf, exp_bus(i));
            check($sformatf("done_at_%0d", i), 32'(bus.o_done), 32'(i == 28));
            check($sformatf("busy_at_%0d", i), 32'(bus.o_busy), 32'd1);
            if (i < 28) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1;
        check("d1_idle_busy", 32'(bus.o_busy), 32'h0);
        check("d1_words", 32'(hs_count - base_hs), 32'd8);
        check("d1_dones", 32'(done_count - base_done), 32'd1);
        check("d1_sb_empty", 32'(sb.size()), 32'd0);

        // Back-pressure: ready low for 5 cycles while word 3 is presented.
        base_hs = hs_count;
        push_dump();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        t = 0;
        while (hs_count < base_hs + 3 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        bus.i_ready = 1'b0;
        t = 0;
        while (!bus.o_valid && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", 32'(bus.o_valid), 32'd1);
            check("stall_data", bus.o_data, stream_ref[3]);
            @(posedge clk);
            #1;
        end
        bus.i_ready = 1'b1;
        wait_done(100);
        @(posedge clk);
        #1;
        check("d2_words", 32'(hs_count - base_hs), 32'd8);
        check("d2_sb_empty", 32'(sb.size()), 32'd0);

        // Micro strobes while busy are discarded and flagged once per cycle.
        base_drop = drop_count;
        push_dump();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        for (int c = 0; c < 28; c++) begin
            bus.i_gpio_from_micro = (c == 2 || c == 3 || c == 6) ? 32'h0180_0000 : 32'h0;
            @(posedge clk);
            #1;
        end
        bus.i_gpio_from_micro = '0;
        check("d3_done", 32'(bus.o_done), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("d3_drops", 32'(drop_count - base_drop), 32'd3);
        check("d3_no_leak", 32'(leak_count), 32'd0);
        check("d3_sb_empty", 32'(sb.size()), 32'd0);

        // Asynchronous reset during SETTLE of word 4, then a clean full dump.
        base_hs = hs_count;
        push_dump();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        t = 0;
        while (hs_count < base_hs + 4 && t < 200) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("rst_sel4_word", bus.o_gpio_to_regf, 32'h0681_0004);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_gpio", bus.o_gpio_to_regf, 32'h0);
        check("arst_data", bus.o_data, 32'h0);
        check("arst_valid", 32'(bus.o_valid), 32'h0);
        check("arst_busy", 32'(bus.o_busy), 32'h0);
        check("arst_done", 32'(bus.o_done), 32'h0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        base_hs = hs_count;
        push_dump();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        wait_done(100);
        @(posedge clk);
        #1;
        check("d4_words", 32'(hs_count - base_hs), 32'd8);
        check("d4_sb_empty", 32'(sb.size()), 32'd0);

        // Start re-pulsed while busy is ignored.
        base_hs = hs_count;
        base_done = done_count;
        push_dump();
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 28; c++) begin
            bus.i_start = (c == 5 || c == 15 || c == 27);
            @(posedge clk);
            #1;
        end
        bus.i_start = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        check("d5_words", 32'(hs_count - base_hs), 32'd8);
        check("d5_dones", 32'(done_count - base_done), 32'd1);
        check("d5_idle", 32'(bus.o_busy), 32'h0);
        check("d5_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
